tlb_multi: RTL and testbench

Parametrised, fully associative, dual-port (instruction + data) MIPS32-style joint TLB for the CP0/MMU path. It is the successor to the fixed 16-entry TLB. It adds:
- configurable depth;
- TLBWR with a Random/Wired replacement counter;
- TLBP probe and TLBR read-back;
- D-bit (modified) fault reporting;
- optional ASID/Global matching.

Translations and probe/read results are registered, one cycle after the request.

---
 rtl/tlb_multi.sv | 191 +++++++++++++++++++
 tb/tb_tlb_multi.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/tlb_multi.sv
// Fully associative dual-port joint TLB with TLBWI/TLBWR/TLBP/TLBR and a Random/Wired counter.
// Define TLB_ASID_EN to store and match ASID and G; otherwise matching uses VPN2 only.
module tlb_multi #(
    parameter  int ENTRIES = 16,
    localparam int IDX_W   = $clog2(ENTRIES)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [31:0]      cp0Index,
    input  logic [31:0]      cp0EntryHi,
    input  logic [31:0]      cp0EntryLo0,
    input  logic [31:0]      cp0EntryLo1,
    input  logic [IDX_W-1:0] cp0Wired,
    input  logic             wiredWe,
    input  logic             tlbwi,
    input  logic             tlbwr,
    input  logic             tlbp,
    input  logic             tlbr,
    input  logic [31:0]      insAddrVirt,
    input  logic [31:0]      dataAddrVirt,
    input  logic             dataWrite,
    output logic [31:0]      insAddrPhy,
    output logic [31:0]      dataAddrPhy,
    output logic             insMiss,
    output logic             dataMiss,
    output logic             insInvalid,
    output logic             dataInvalid,
    output logic             dataModified,
    output logic [31:0]      probeIndex,
    output logic             probeDone,
    output logic [31:0]      readEntryHi,
    output logic [31:0]      readEntryLo0,
    output logic [31:0]      readEntryLo1,
    output logic             readDone,
    output logic [IDX_W-1:0] randomIndex
);

    localparam logic [IDX_W-1:0] LAST = IDX_W'(ENTRIES - 1);

    // vld_q marks entries written since reset, so cleared entries never match.
    logic [ENTRIES-1:0] vld_q, d0_q, v0_q, d1_q, v1_q;
    logic [18:0]        vpn2_q [ENTRIES];
    logic [19:0]        pfn0_q [ENTRIES];
    logic [19:0]        pfn1_q [ENTRIES];
`ifdef TLB_ASID_EN
    logic [7:0]         asid_q [ENTRIES];
    logic [ENTRIES-1:0] g_q;
`endif

    logic             wr_en, probe_en, read_en;
    logic [IDX_W-1:0] wr_idx, rd_idx;
    assign wr_en    = tlbwi | tlbwr;
    assign wr_idx   = tlbwi ? cp0Index[IDX_W-1:0] : randomIndex;
    assign probe_en = tlbp & ~wr_en;
    assign read_en  = tlbr & ~wr_en & ~tlbp;
    assign rd_idx   = cp0Index[IDX_W-1:0];

    logic unused_bits;
    assign unused_bits = ^{cp0Index, cp0EntryHi[12:0], cp0EntryLo0[31:26], cp0EntryLo0[5:0],
                           cp0EntryLo1[31:26], cp0EntryLo1[5:0]};

    function automatic logic [IDX_W-1:0] first_idx(input logic [ENTRIES-1:0] m);
        logic [IDX_W-1:0] r;
        r = '0;
        for (int i = ENTRIES - 1; i >= 0; i--)
            if (m[i]) r = IDX_W'(i);
        return r;
    endfunction

    logic [ENTRIES-1:0] ins_hit, data_hit, probe_hit;
    logic [IDX_W-1:0]   ins_idx, data_idx, probe_idx;
    logic               ins_v, data_v, data_d;
    logic [19:0]        ins_pfn, data_pfn;
    logic [7:0]         rd_asid;
    logic               rd_g;

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned and no latch is inferred.
        ins_hit   = '0;
        data_hit  = '0;
        probe_hit = '0;
        rd_asid   = '0;
        rd_g      = 1'b0;
        for (int i = 0; i < ENTRIES; i++) begin
            logic asid_ok;
`ifdef TLB_ASID_EN
            asid_ok = g_q[i] || (asid_q[i] == cp0EntryHi[7:0]);
`else
            asid_ok = 1'b1;
`endif
            ins_hit[i]   = vld_q[i] && asid_ok && (vpn2_q[i] == insAddrVirt[31:13]);
            data_hit[i]  = vld_q[i] && asid_ok && (vpn2_q[i] == dataAddrVirt[31:13]);
            probe_hit[i] = vld_q[i] && asid_ok && (vpn2_q[i] == cp0EntryHi[31:13]);
        end
        ins_idx   = first_idx(ins_hit);
        data_idx  = first_idx(data_hit);
        probe_idx = first_idx(probe_hit);
        ins_v     = insAddrVirt[12]  ? v1_q[ins_idx]    : v0_q[ins_idx];
        ins_pfn   = insAddrVirt[12]  ? pfn1_q[ins_idx]  : pfn0_q[ins_idx];
        data_v    = dataAddrVirt[12] ? v1_q[data_idx]   : v0_q[data_idx];
        data_d    = dataAddrVirt[12] ? d1_q[data_idx]   : d0_q[data_idx];
        data_pfn  = dataAddrVirt[12] ? pfn1_q[data_idx] : pfn0_q[data_idx];
`ifdef TLB_ASID_EN
        rd_asid   = asid_q[rd_idx];
        rd_g      = g_q[rd_idx];
`endif
    end

    // NOTE: entries are flops rather than RAM, so the async reset clears the whole array at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
            d0_q  <= '0;
            v0_q  <= '0;
            d1_q  <= '0;
            v1_q  <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                vpn2_q[i] <= '0;
                pfn0_q[i] <= '0;
                pfn1_q[i] <= '0;
`ifdef TLB_ASID_EN
                asid_q[i] <= '0;
`endif
            end
`ifdef TLB_ASID_EN
            g_q <= '0;
`endif
        end else if (wr_en) begin
            // NOTE: non-blocking, so lookups sampled at this same edge still see the old entry.
            vld_q[wr_idx]  <= 1'b1;
            vpn2_q[wr_idx] <= cp0EntryHi[31:13];
            pfn0_q[wr_idx] <= cp0EntryLo0[25:6];
            d0_q[wr_idx]   <= cp0EntryLo0[2];
            v0_q[wr_idx]   <= cp0EntryLo0[1];
            pfn1_q[wr_idx] <= cp0EntryLo1[25:6];
            d1_q[wr_idx]   <= cp0EntryLo1[2];
            v1_q[wr_idx]   <= cp0EntryLo1[1];
`ifdef TLB_ASID_EN
            asid_q[wr_idx] <= cp0EntryHi[7:0];
            g_q[wr_idx]    <= cp0EntryLo0[0] & cp0EntryLo1[0];
`endif
        end
    end

    // Random shows the Wired value for one cycle before wrapping back to the top.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            randomIndex <= LAST;
        else if (wiredWe || cp0Wired >= LAST || randomIndex == cp0Wired)
            randomIndex <= LAST;
        else
            randomIndex <= randomIndex - 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            insAddrPhy   <= '0;
            dataAddrPhy  <= '0;
            insMiss      <= 1'b1;
            dataMiss     <= 1'b1;
            insInvalid   <= 1'b0;
            dataInvalid  <= 1'b0;
            dataModified <= 1'b0;
            probeIndex   <= '0;
            probeDone    <= 1'b0;
            readEntryHi  <= '0;
            readEntryLo0 <= '0;
            readEntryLo1 <= '0;
            readDone     <= 1'b0;
        end else begin
            insMiss      <= ~|ins_hit;
            insInvalid   <= |ins_hit & ~ins_v;
            insAddrPhy   <= (|ins_hit && ins_v) ? {ins_pfn, insAddrVirt[11:0]} : '0;
            dataMiss     <= ~|data_hit;
            dataInvalid  <= |data_hit & ~data_v;
            dataModified <= |data_hit & data_v & dataWrite & ~data_d;
            dataAddrPhy  <= (|data_hit && data_v && !(dataWrite && !data_d))
                            ? {data_pfn, dataAddrVirt[11:0]} : '0;
            probeDone    <= probe_en;
            readDone     <= read_en;
            if (probe_en)
                probeIndex <= (|probe_hit) ? 32'(probe_idx) : 32'h8000_0000;
            if (read_en) begin
                readEntryHi  <= {vpn2_q[rd_idx], 5'b0, rd_asid};
                readEntryLo0 <= {6'b0, pfn0_q[rd_idx], 3'b0, d0_q[rd_idx], v0_q[rd_idx], rd_g};
                readEntryLo1 <= {6'b0, pfn1_q[rd_idx], 3'b0, d1_q[rd_idx], v1_q[rd_idx], rd_g};
            end
        end
    end

endmodule

// File: tb/tb_tlb_multi.sv
// Directed, table-driven bench for tlb_multi (16 entries); follows TLB_ASID_EN when defined.
module tb_tlb_multi;
    localparam int N  = 16;
    localparam int IW = 4;
`ifdef TLB_ASID_EN
    localparam bit ASID = 1'b1;
`else
    localparam bit ASID = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [31:0]   cp0Index = '0, cp0EntryHi = '0, cp0EntryLo0 = '0, cp0EntryLo1 = '0;
    logic [IW-1:0] cp0Wired = '0;
    logic          wiredWe = 1'b0, tlbwi = 1'b0, tlbwr = 1'b0, tlbp = 1'b0, tlbr = 1'b0;
    logic [31:0]   insAddrVirt = '0, dataAddrVirt = '0;
    logic          dataWrite = 1'b0;
    logic [31:0]   insAddrPhy, dataAddrPhy, probeIndex, readEntryHi, readEntryLo0, readEntryLo1;
    logic          insMiss, dataMiss, insInvalid, dataInvalid, dataModified, probeDone, readDone;
    logic [IW-1:0] randomIndex;

    tlb_multi #(.ENTRIES(N)) dut (
        .clk(clk), .rst_n(rst_n),
        .cp0Index(cp0Index), .cp0EntryHi(cp0EntryHi),
        .cp0EntryLo0(cp0EntryLo0), .cp0EntryLo1(cp0EntryLo1),
        .cp0Wired(cp0Wired), .wiredWe(wiredWe),
        .tlbwi(tlbwi), .tlbwr(tlbwr), .tlbp(tlbp), .tlbr(tlbr),
        .insAddrVirt(insAddrVirt), .dataAddrVirt(dataAddrVirt), .dataWrite(dataWrite),
        .insAddrPhy(insAddrPhy), .dataAddrPhy(dataAddrPhy),
        .insMiss(insMiss), .dataMiss(dataMiss),
        .insInvalid(insInvalid), .dataInvalid(dataInvalid), .dataModified(dataModified),
        .probeIndex(probeIndex), .probeDone(probeDone),
        .readEntryHi(readEntryHi), .readEntryLo0(readEntryLo0), .readEntryLo1(readEntryLo1),
        .readDone(readDone), .randomIndex(randomIndex)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [31:0] ins_va;
        logic [31:0] data_va;
        logic        dw;
        logic [31:0] ins_pa;
        logic        ins_miss;
        logic        ins_inv;
        logic [31:0] data_pa;
        logic        data_miss;
        logic        data_inv;
        logic        data_mod;
    } vec_t;

    localparam int NV = 7;
    vec_t vec [NV];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int idx, input logic [31:0] hi, input logic [31:0] lo0, input logic [31:0] lo1);
        cp0Index    = idx;
        cp0EntryHi  = hi;
        cp0EntryLo0 = lo0;
        cp0EntryLo1 = lo1;
        tlbwi = 1'b1;
        tick();
        tlbwi = 1'b0;
        cp0EntryHi = '0;
    endtask

    task automatic rd(input int idx);
        cp0Index = idx;
        tlbr = 1'b1;
        tick();
        tlbr = 1'b0;
    endtask

    task automatic data_lookup(input logic [31:0] va, input logic w);
        dataAddrVirt = va;
        dataWrite    = w;
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] exp_rnd;

        // Reset state, sampled while reset is still held.
        #12;
        check("rst_random", 32'(randomIndex), 32'(N - 1));
        check("rst_ins_miss", 32'(insMiss), 32'd1);
        check("rst_data_miss", 32'(dataMiss), 32'd1);
        check("rst_probe_done", 32'(probeDone), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Every lookup misses on a cleared TLB.
        insAddrVirt  = 32'h0000_0000;
        dataAddrVirt = 32'h7FFF_F000;
        tick();
        check("clr_ins_miss_a", 32'(insMiss), 32'd1);
        check("clr_ins_pa_a", insAddrPhy, 32'h0);
        check("clr_data_miss_a", 32'(dataMiss), 32'd1);
        check("clr_data_pa_a", dataAddrPhy, 32'h0);
        insAddrVirt  = 32'h7FFF_F000;
        dataAddrVirt = 32'h0000_0000;
        tick();
        check("clr_ins_miss_b", 32'(insMiss), 32'd1);
        check("clr_data_miss_b", 32'(dataMiss), 32'd1);
        check("clr_data_inv_b", 32'(dataInvalid), 32'd0);

        // Entries used by the lookup table; index 5 duplicates VPN2 7 to test lowest-index priority.
        wr(0, 32'h0000_E000, 32'h0048_D147, 32'h0159_E241);
        wr(5, 32'h0000_E000, 32'h0044_4447, 32'h0044_4447);
        wr(2, 32'h7F00_A000, 32'h008C_CCC3, 32'h0002_AF07);
        wr(3, 32'h2468_005A, 32'h02AA_AA87, 32'h0155_5543);

        vec[0] = '{32'h0000_F324, 32'h0000_E678, 1'b0, 32'h0,         1'b0, 1'b1, 32'h1234_5678, 1'b0, 1'b0, 1'b0};
        vec[1] = '{32'h0000_E678, 32'h7F00_A233, 1'b1, 32'h1234_5678, 1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 1'b1};
        vec[2] = '{32'h7F00_A233, 32'h7F00_A233, 1'b0, 32'h2333_3233, 1'b0, 1'b0, 32'h2333_3233, 1'b0, 1'b0, 1'b0};
        vec[3] = '{32'h7F00_B010, 32'h7F00_B010, 1'b1, 32'h00AB_C010, 1'b0, 1'b0, 32'h00AB_C010, 1'b0, 1'b0, 1'b0};
        vec[4] = '{32'h0000_1000, 32'h0000_2468, 1'b1, 32'h0,         1'b1, 1'b0, 32'h0,         1'b1, 1'b0, 1'b0};
        vec[5] = '{32'h2468_1004, 32'h0000_F324, 1'b1, 32'h5555_5004, 1'b0, 1'b0, 32'h0,         1'b0, 1'b1, 1'b0};
        vec[6] = '{32'h2468_0FFC, 32'h2468_1000, 1'b1, 32'hAAAA_AFFC, 1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 1'b1};

        for (int i = 0; i < NV; i++) begin
            insAddrVirt  = vec[i].ins_va;
            dataAddrVirt = vec[i].data_va;
            dataWrite    = vec[i].dw;
            tick();
            check($sformatf("v%0d_ins_pa", i), insAddrPhy, vec[i].ins_pa);
            check($sformatf("v%0d_ins_miss", i), 32'(insMiss), 32'(vec[i].ins_miss));
            check($sformatf("v%0d_ins_inv", i), 32'(insInvalid), 32'(vec[i].ins_inv));
            check($sformatf("v%0d_data_pa", i), dataAddrPhy, vec[i].data_pa);
            check($sformatf("v%0d_data_miss", i), 32'(dataMiss), 32'(vec[i].data_miss));
            check($sformatf("v%0d_data_inv", i), 32'(dataInvalid), 32'(vec[i].data_inv));
            check($sformatf("v%0d_data_mod", i), 32'(dataModified), 32'(vec[i].data_mod));
        end
        dataWrite = 1'b0;

        // A lookup sampled at the write edge sees the old contents; the next one sees the new entry.
        dataAddrVirt = 32'h0020_0ABC;
        cp0Index     = 6;
        cp0EntryHi   = 32'h0020_0000;
        cp0EntryLo0  = 32'h01DD_DDC7;
        cp0EntryLo1  = 32'h01DD_DDC7;
        tlbwi = 1'b1;
        tick();
        tlbwi = 1'b0;
        cp0EntryHi = '0;
        check("wr_same_edge_miss", 32'(dataMiss), 32'd1);
        tick();
        check("wr_next_edge_miss", 32'(dataMiss), 32'd0);
        check("wr_next_edge_pa", dataAddrPhy, 32'h7777_7ABC);

        // ASID/G matching.
        wr(4, 32'h0008_0005, 32'h0032_BF86, 32'h0032_BF86);
        cp0EntryHi = 32'h0000_0006;
        data_lookup(32'h0008_0100, 1'b0);
        check("asid_other_miss", 32'(dataMiss), ASID ? 32'd1 : 32'd0);
        check("asid_other_pa", dataAddrPhy, ASID ? 32'h0 : 32'h0CAF_E100);
        cp0EntryHi = 32'h0000_0005;
        data_lookup(32'h0008_0100, 1'b0);
        check("asid_same_pa", dataAddrPhy, 32'h0CAF_E100);
        wr(4, 32'h0008_0005, 32'h0032_BF87, 32'h0032_BF87);
        cp0EntryHi = 32'h0000_0006;
        data_lookup(32'h0008_0100, 1'b0);
        check("asid_global_miss", 32'(dataMiss), 32'd0);
        check("asid_global_pa", dataAddrPhy, 32'h0CAF_E100);

        // TLBP hit on index 3, then a probe for an absent VPN2.
        cp0EntryHi = 32'h2468_005A;
        tlbp = 1'b1;
        tick();
        tlbp = 1'b0;
        check("probe_hit_done", 32'(probeDone), 32'd1);
        check("probe_hit_idx", probeIndex, 32'd3);
        tick();
        check("probe_done_pulse", 32'(probeDone), 32'd0);
        check("probe_idx_hold", probeIndex, 32'd3);
        cp0EntryHi = 32'h0000_2000;
        tlbp = 1'b1;
        tick();
        tlbp = 1'b0;
        check("probe_miss_idx", probeIndex, 32'h8000_0000);

        // TLBR of index 3.
        rd(3);
        check("read_done", 32'(readDone), 32'd1);
        check("read_hi", readEntryHi, ASID ? 32'h2468_005A : 32'h2468_0000);
        check("read_lo0", readEntryLo0, ASID ? 32'h02AA_AA87 : 32'h02AA_AA86);
        check("read_lo1", readEntryLo1, ASID ? 32'h0155_5543 : 32'h0155_5542);
        tick();
        check("read_done_pulse", 32'(readDone), 32'd0);

        // Random/Wired: force to the top, TLBWR uses the current value, then walk down to Wired.
        cp0Wired = 4'd2;
        wiredWe  = 1'b1;
        tick();
        wiredWe  = 1'b0;
        check("rnd_forced", 32'(randomIndex), 32'(N - 1));
        cp0EntryHi  = 32'h1357_0000;
        cp0EntryLo0 = 32'h0000_0047;
        cp0EntryLo1 = 32'h0000_0047;
        tlbwr = 1'b1;
        tick();
        tlbwr = 1'b0;
        exp_rnd = 32'(N - 2);
        check("rnd_after_tlbwr", 32'(randomIndex), exp_rnd);
        for (int k = 0; k < 16; k++) begin
            tick();
            exp_rnd = (exp_rnd == 32'd2) ? 32'(N - 1) : exp_rnd - 32'd1;
            check($sformatf("rnd_seq%0d", k), 32'(randomIndex), exp_rnd);
        end
        rd(N - 1);
        check("tlbwr_hi", readEntryHi, 32'h1357_0000);
        check("tlbwr_lo0", readEntryLo0, ASID ? 32'h0000_0047 : 32'h0000_0046);

        // A burst of TLBWRs never reaches the wired entries 0 and 1.
        cp0EntryHi = 32'hFFFF_E000;
        tlbwr = 1'b1;
        for (int k = 0; k < 16; k++) tick();
        tlbwr = 1'b0;
        rd(0);
        check("wired0_hi", readEntryHi, 32'h0000_E000);
        check("wired0_lo0", readEntryLo0, ASID ? 32'h0048_D147 : 32'h0048_D146);
        rd(1);
        check("wired1_hi", readEntryHi, 32'h0);
        check("wired1_lo1", readEntryLo1, 32'h0);

        // Wired at ENTRIES-1 pins Random at the top.
        cp0Wired = 4'd15;
        tick();
        for (int k = 0; k < 3; k++) begin
            tick();
            check($sformatf("rnd_pinned%0d", k), 32'(randomIndex), 32'(N - 1));
        end
        cp0Wired = 4'd0;

        // Asynchronous reset while a probe is pending.
        cp0EntryHi = 32'h0000_E000;
        tlbp = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_probe_done", 32'(probeDone), 32'd0);
        check("arst_probe_idx", probeIndex, 32'h0);
        check("arst_data_miss", 32'(dataMiss), 32'd1);
        check("arst_read_hi", readEntryHi, 32'h0);
        tick();
        check("arst_held_probe_done", 32'(probeDone), 32'd0);
        tlbp = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        data_lookup(32'h0000_E678, 1'b0);
        check("arst_cleared_miss", 32'(dataMiss), 32'd1);
        check("arst_cleared_pa", dataAddrPhy, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
